lcd_fill_engine: RTL

- Downstream of the AHB-lite LCD register block.
- Consumes its `color_en` start pulse, the `LCD_en` gate and the four window registers (start/end column, start/end page).
- Drives an 8080-style parallel write bus to an ILI9341-class panel: column-address-set, page-address-set, memory-write, then a solid-colour fill of every pixel in the window.
- Software writes the window and colour registers first, then writes the colour-start register.

---
 rtl/lcd_fill_engine.sv | 219 +++++++++++++++++++++
 1 files changed

// File: rtl/lcd_fill_engine.sv
// lcd_fill_engine: drives CASET/PASET/RAMWR then a solid colour fill
// over an 8080-style parallel bus to an ILI9341-class panel.
module lcd_fill_engine #(
    parameter int         WR_LOW    = 2,
    parameter int         WR_HIGH   = 2,
    parameter logic [7:0] CMD_CASET = 8'h2A,
    parameter logic [7:0] CMD_PASET = 8'h2B,
    parameter logic [7:0] CMD_RAMWR = 8'h2C
) (
    input  logic        HCLK,
    input  logic        HRESET,
    input  logic        lcd_en,
    input  logic        color_en,
    input  logic [31:0] set_sc,
    input  logic [31:0] set_ec,
    input  logic [31:0] set_sp,
    input  logic [31:0] set_ep,
    input  logic [15:0] color,
    output logic        LCD_CS,
    output logic        LCD_RS,
    output logic        LCD_WR,
    output logic        LCD_RD,
    output logic [15:0] LCD_DATA,
    output logic        busy,
    output logic        done,
    output logic        err
);

    localparam int WORD = WR_LOW + WR_HIGH;
    localparam int PW   = (WORD > 1) ? $clog2(WORD) : 1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_CASET_C,
        S_CASET_P,
        S_PASET_C,
        S_PASET_P,
        S_RAMWR_C,
        S_PIXEL
    } state_t;

    state_t        state, state_n;
    logic [PW-1:0] ph, ph_n;
    logic [1:0]    idx, idx_n;
    logic [15:0]   x, x_n, y, y_n;
    logic [15:0]   sc_r, ec_r, sp_r, ep_r, color_r;
    logic          accept, start_bad, word_end, last_px, done_n;
    logic          cs_d, wr_d, rs_d;
    logic [15:0]   data_d;
    logic          unused_hi;

    assign unused_hi = ^{set_sc[31:16], set_ec[31:16],
                         set_sp[31:16], set_ep[31:16]};
    assign LCD_RD    = 1'b1;

    function automatic logic [7:0] pbyte(input logic [15:0] a,
                                         input logic [15:0] b,
                                         input logic [1:0]  i);
        case (i)
            2'd0:    pbyte = a[15:8];
            2'd1:    pbyte = a[7:0];
            2'd2:    pbyte = b[15:8];
            default: pbyte = b[7:0];
        endcase
    endfunction

    // Next-state: word sequencing, sub-phase timing and x/y pixel walk
    always_comb begin
        state_n   = state;
        ph_n      = ph;
        idx_n     = idx;
        x_n       = x;
        y_n       = y;
        done_n    = 1'b0;
        accept    = (state == S_IDLE) && color_en && lcd_en;
        start_bad = accept && ((set_ec[15:0] < set_sc[15:0]) ||
                               (set_ep[15:0] < set_sp[15:0]));
        word_end  = (ph == PW'(WORD - 1));
        last_px   = (x == ec_r) && (y == ep_r);
        if (state != S_IDLE) begin
            ph_n = word_end ? '0 : ph + PW'(1);
        end
        unique case (state)
            S_IDLE: begin
                if (accept && !start_bad) begin
                    state_n = S_CASET_C;
                    ph_n    = '0;
                end
            end
            S_CASET_C: begin
                if (word_end) begin
                    state_n = S_CASET_P;
                    idx_n   = 2'd0;
                end
            end
            S_CASET_P: begin
                if (word_end) begin
                    idx_n = idx + 2'd1;
                    if (idx == 2'd3) state_n = S_PASET_C;
                end
            end
            S_PASET_C: begin
                if (word_end) begin
                    state_n = S_PASET_P;
                    idx_n   = 2'd0;
                end
            end
            S_PASET_P: begin
                if (word_end) begin
                    idx_n = idx + 2'd1;
                    if (idx == 2'd3) state_n = S_RAMWR_C;
                end
            end
            S_RAMWR_C: begin
                if (word_end) begin
                    state_n = S_PIXEL;
                    x_n     = sc_r;
                    y_n     = sp_r;
                end
            end
            S_PIXEL: begin
                if (word_end) begin
                    if (last_px) begin
                        state_n = S_IDLE;
                        done_n  = 1'b1;
                    end else if (x == ec_r) begin
                        x_n = sc_r;
                        y_n = y + 16'd1;
                    end else begin
                        x_n = x + 16'd1;
                    end
                end
            end
            default: state_n = S_IDLE;
        endcase
    end

    // Bus word decode from the upcoming state so outputs leave a flop
    always_comb begin
        cs_d   = (state_n == S_IDLE);
        wr_d   = cs_d || (ph_n >= PW'(WR_LOW));
        rs_d   = 1'b1;
        data_d = 16'h0000;
        unique case (state_n)
            S_CASET_C: begin
                rs_d   = 1'b0;
                data_d = {8'h00, CMD_CASET};
            end
            S_CASET_P: data_d = {8'h00, pbyte(sc_r, ec_r, idx_n)};
            S_PASET_C: begin
                rs_d   = 1'b0;
                data_d = {8'h00, CMD_PASET};
            end
            S_PASET_P: data_d = {8'h00, pbyte(sp_r, ep_r, idx_n)};
            S_RAMWR_C: begin
                rs_d   = 1'b0;
                data_d = {8'h00, CMD_RAMWR};
            end
            S_PIXEL:   data_d = color_r;
            default:   data_d = 16'h0000;
        endcase
    end

    // Sequencer state, phase, parameter index and pixel counters
    always_ff @(posedge HCLK) begin
        if (HRESET) begin
            state <= S_IDLE;
            ph    <= '0;
            idx   <= 2'd0;
            x     <= 16'd0;
            y     <= 16'd0;
        end else begin
            state <= state_n;
            ph    <= ph_n;
            idx   <= idx_n;
            x     <= x_n;
            y     <= y_n;
        end
    end

    // Snapshot window and colour at accept; later input changes are ignored
    always_ff @(posedge HCLK) begin
        if (HRESET) begin
            sc_r    <= 16'd0;
            ec_r    <= 16'd0;
            sp_r    <= 16'd0;
            ep_r    <= 16'd0;
            color_r <= 16'd0;
        end else if (accept) begin
            sc_r    <= set_sc[15:0];
            ec_r    <= set_ec[15:0];
            sp_r    <= set_sp[15:0];
            ep_r    <= set_ep[15:0];
            color_r <= color;
        end
    end

    // Registered panel bus and status pulses
    always_ff @(posedge HCLK) begin
        if (HRESET) begin
            LCD_CS   <= 1'b1;
            LCD_RS   <= 1'b1;
            LCD_WR   <= 1'b1;
            LCD_DATA <= 16'h0000;
            busy     <= 1'b0;
            done     <= 1'b0;
            err      <= 1'b0;
        end else begin
            LCD_CS   <= cs_d;
            LCD_RS   <= rs_d;
            LCD_WR   <= wr_d;
            LCD_DATA <= data_d;
            busy     <= !cs_d;
            done     <= done_n;
            err      <= start_bad;
        end
    end

endmodule
